// File: rtl/rr_reg_arbiter.sv
// Purpose: 4-way round-robin arbiter owning a shared DW-bit data register q.
// Latency: grant 1 cycle after IDLE sees a request; q/q_valid 1 cycle after each owner write.
// Backpressure: a grant is held while req[owner] stays high, up to MAX_HOLD writes, then forced release.
// Ports: clk, reset_n (sync, active low) | req[3:0], din[4*DW-1:0] (slice i = requester i)
//        gnt[3:0] one-hot/zero owner, q/q_valid shared register + write pulse,
//        busy (state BUSY), timeout (one-cycle pulse on forced release).
module rr_reg_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [DW-1:0]   q,
    output logic            q_valid,
    output logic            busy,
    output logic            timeout
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY     = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]    state;
    logic [1:0]    owner;
    logic [1:0]    last_winner;
    logic [7:0]    hold_cnt;
    logic [1:0]    winner;
    logic          any_req;
    logic          owner_req;
    logic [DW-1:0] owner_dat;

    // Round-robin search: start one past the last winner, ascending with wrap.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last_winner;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_winner + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req   = |req;
    assign owner_req = req[owner];
    assign owner_dat = din[int'(owner)*DW +: DW];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= 2'd0;
            last_winner <= 2'd3;
            hold_cnt    <= 8'd0;
            gnt         <= 4'b0000;
            q           <= '0;
            q_valid     <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // Pulses default low; only a BUSY write or forced release raises them.
            q_valid <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_BUSY;
                        owner       <= winner;
                        last_winner <= winner;
                        hold_cnt    <= 8'd0;
                        gnt         <= 4'b0001 << winner;
                        busy        <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // A dropped owner request wins over the hold limit: no write, no timeout.
                    if (!owner_req) begin
                        state <= ST_COOLDOWN;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end else begin
                        q       <= owner_dat;
                        q_valid <= 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            state   <= ST_COOLDOWN;
                            gnt     <= 4'b0000;
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 8;

    logic            clk;
    logic            reset_n;
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [DW-1:0]   q;
    logic            q_valid;
    logic            busy;
    logic            timeout;

    int errors = 0;
    int checks = 0;

    rr_reg_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, transaction view: who holds the grant, how many writes
    // it has made, whether we are in the gap after a release.
    bit          m_granted;
    bit          m_gap;
    int          m_owner;
    int          m_writes;
    int          m_last;
    logic [DW-1:0] m_q;
    bit          m_qv;
    bit          m_to;
    bit          prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic [3:0] r, input logic [4*DW-1:0] d);
        m_qv = 1'b0;
        m_to = 1'b0;
        if (!rn) begin
            m_granted = 0; m_gap = 0; m_owner = 0; m_writes = 0; m_last = 3; m_q = '0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_granted) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (r[c]) begin
                    m_granted = 1; m_owner = c; m_last = c; m_writes = 0;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_granted = 0; m_gap = 1;
        end else begin
            m_q = d[m_owner*DW +: DW];
            m_qv = 1'b1;
            m_writes++;
            if (m_writes == MAX_HOLD) begin
                m_granted = 0; m_gap = 1; m_to = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cyc(input logic rn, input logic [3:0] r, input logic [4*DW-1:0] d);
        logic [3:0] exp_gnt;
        reset_n = rn; req = r; din = d;
        model_step(rn, r, d);
        @(posedge clk);
        #1;
        exp_gnt = m_granted ? (4'b0001 << m_owner) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("q", 32'(q), 32'(m_q));
        chk("q_valid", 32'(q_valid), 32'(m_qv));
        chk("busy", 32'(busy), 32'(m_granted));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("inv_busy_gnt", 32'(busy), 32'(gnt != 4'b0000));
        if (timeout) chk("inv_timeout_prev_busy", 32'(prev_busy), 32'd1);
        prev_busy = busy;
    endtask

    function automatic logic [4*DW-1:0] rnd_din();
        return {$urandom, $urandom} & {(4*DW){1'b1}};
    endfunction

    initial begin
        int qv_cnt;
        int to_cnt;
        logic [4*DW-1:0] dv;
        reset_n = 1'b0; req = 4'b0; din = '0; prev_busy = 1'b0;
        m_last = 3; m_q = '0;

        // Reset state
        cyc(1'b0, 4'b0000, rnd_din());
        cyc(1'b0, 4'b1111, rnd_din());
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_q", 32'(q), 32'd0);

        // Requesters 1 and 2; 1 wins from reset priority, then 2 after release
        cyc(1'b1, 4'b0110, rnd_din());
        chk("s028_first_gnt", 32'(gnt), 32'b0010);
        cyc(1'b1, 4'b0110, rnd_din());
        cyc(1'b1, 4'b0100, rnd_din());
        chk("s028_cooldown_gnt", 32'(gnt), 32'd0);
        cyc(1'b1, 4'b0100, rnd_din());
        cyc(1'b1, 4'b0100, rnd_din());
        chk("s028_second_gnt", 32'(gnt), 32'b0100);
        cyc(1'b1, 4'b0000, rnd_din());
        cyc(1'b1, 4'b0000, rnd_din());

        // All requesting, each drops after 2 BUSY cycles: rotation 0,1,2,3,0
        cyc(1'b0, 4'b0000, rnd_din());
        for (int g = 0; g < 5; g++) begin
            logic [3:0] drop;
            cyc(1'b1, 4'b1111, rnd_din());
            chk("s029_rotation", 32'(gnt), 32'(4'b0001 << (g % 4)));
            cyc(1'b1, 4'b1111, rnd_din());
            cyc(1'b1, 4'b1111, rnd_din());
            drop = 4'b1111 & ~(4'b0001 << (g % 4));
            cyc(1'b1, drop, rnd_din());
            chk("s029_gap", 32'(gnt), 32'd0);
            cyc(1'b1, 4'b1111, rnd_din());
        end

        // Forced release after MAX_HOLD writes of 8'hA5 from requester 2
        cyc(1'b0, 4'b0000, rnd_din());
        dv = rnd_din();
        dv[2*DW +: DW] = 8'hA5;
        qv_cnt = 0; to_cnt = 0;
        for (int i = 0; i < 1 + MAX_HOLD; i++) begin
            cyc(1'b1, 4'b0100, dv);
            if (q_valid && q == 8'hA5) qv_cnt++;
            if (timeout) to_cnt++;
        end
        chk("s030_writes", 32'(qv_cnt), 32'(MAX_HOLD));
        chk("s030_timeout_cnt", 32'(to_cnt), 32'd1);
        chk("s030_timeout_at_release", 32'({timeout, gnt}), 32'b10000);
        cyc(1'b1, 4'b0100, dv);
        chk("s030_timeout_one_cycle", 32'(timeout), 32'd0);
        cyc(1'b1, 4'b0100, dv);
        chk("s030_regrant", 32'(gnt), 32'b0100);
        chk("s030_q_kept", 32'(q), 32'hA5);

        // Owner drops exactly at the hold limit: no write, no timeout
        cyc(1'b0, 4'b0000, rnd_din());
        cyc(1'b1, 4'b0100, rnd_din());
        for (int i = 0; i < MAX_HOLD - 1; i++) cyc(1'b1, 4'b0100, rnd_din());
        cyc(1'b1, 4'b0000, rnd_din());
        chk("s031_timeout", 32'(timeout), 32'd0);
        chk("s031_q_valid", 32'(q_valid), 32'd0);
        chk("s031_gnt", 32'(gnt), 32'd0);

        // Reset in the third BUSY cycle of requester 3
        cyc(1'b0, 4'b0000, rnd_din());
        cyc(1'b1, 4'b1000, rnd_din());
        chk("s032_gnt3", 32'(gnt), 32'b1000);
        cyc(1'b1, 4'b1000, rnd_din());
        cyc(1'b1, 4'b1000, rnd_din());
        cyc(1'b0, 4'b1000, rnd_din());
        chk("s032_abort", 32'({gnt, q, q_valid}), 32'd0);
        cyc(1'b1, 4'b1001, rnd_din());
        chk("s032_winner0", 32'(gnt), 32'b0001);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic rn;
            logic [3:0] r;
            rn = ($urandom_range(0, 63) != 0);
            r  = 4'($urandom);
            if ($urandom_range(0, 3) == 0 && m_granted) r[m_owner] = 1'b0;
            else if (m_granted) r[m_owner] = 1'b1;
            cyc(rn, r, rnd_din());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
